// File: rtl/mips_check_port.sv
// mips_check_port
//   Hardware end of the CPU check channel. Sits beside the single-cycle MIPS
//   datapath, spots committed CHECK instructions (opcode 6'b111111) and queues
//   {tag, pc, rs value} for the output monitor. When the queue is full the
//   CPU is stalled and keeps re-presenting the same CHECK until it fits.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   instr_i           instruction committing this cycle
//   commit_i          instr_i commits this cycle
//   pc_i              pc of instr_i
//   rs_data_i         register-file read of rs (instr_i[25:21])
//   stall_o           hold pc/instr; the CHECK is not accepted this cycle
//   chk_valid_o       head entry valid
//   chk_ready_i       consumer accepts head entry
//   chk_tag_o         head entry tag (instr_i[TAG_W-1:0] at commit)
//   chk_pc_o          head entry pc
//   chk_data_o        head entry rs value
//   chk_total_o       number of accepted CHECKs, wraps 16'hFFFF -> 0
//   dbg_state         occupancy state (0 empty, 1 partial, 2 full)
//
// Handshake: an entry transfers on every rising edge where chk_valid_o and
// chk_ready_i are both high. chk_valid_o never depends on chk_ready_i, and
// while chk_valid_o=1 and chk_ready_i=0 the payload outputs hold.

module mips_check_port #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] instr_i,
    input  logic             commit_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [WIDTH-1:0] rs_data_i,
    output logic             stall_o,
    output logic             chk_valid_o,
    input  logic             chk_ready_i,
    output logic [TAG_W-1:0] chk_tag_o,
    output logic [WIDTH-1:0] chk_pc_o,
    output logic [WIDTH-1:0] chk_data_o,
    output logic [15:0]      chk_total_o,
    output logic [1:0]       dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] CNT_LAST = (AW + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_PART  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];

    // Extra wrap bit on each pointer distinguishes full from empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic [15:0] total;

    occ_state_t state;
    occ_state_t state_nxt;

    logic is_chk;
    logic full;
    logic empty;
    logic push;
    logic pop;

    // Only the opcode and the tag field matter; the rest of the word is ignored.
    logic unused_instr;
    assign unused_instr = ^instr_i;

    assign is_chk = commit_i && (instr_i[WIDTH-1:WIDTH-6] == 6'b111111);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty  = (wr_ptr == rd_ptr);
    assign count  = wr_ptr - rd_ptr;

    // Stall looks only at the registered fill level, so a pop in the same
    // cycle does not release it and there is no ready-to-stall path.
    assign stall_o = rst_n && is_chk && full;

    assign push = is_chk && !full;
    assign pop  = !empty && chk_ready_i;

    assign chk_valid_o = !empty;
    assign chk_total_o = total;
    assign dbg_state   = state;

    // Payload is forced to zero when nothing is buffered so stale entries
    // left in the storage after a reset never show on the outputs.
    assign chk_tag_o  = empty ? '0 : tag_mem[rd_ptr[AW-1:0]];
    assign chk_pc_o   = empty ? '0 : pc_mem[rd_ptr[AW-1:0]];
    assign chk_data_o = empty ? '0 : data_mem[rd_ptr[AW-1:0]];

    // Storage needs no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            tag_mem[wr_ptr[AW-1:0]]  <= instr_i[TAG_W-1:0];
            pc_mem[wr_ptr[AW-1:0]]   <= pc_i;
            data_mem[wr_ptr[AW-1:0]] <= rs_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            total  <= '0;
            state  <= OCC_EMPTY;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                total  <= total + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            state <= state_nxt;
        end
    end

    // Occupancy state tracks the pointer difference; push is impossible
    // when full, so FULL only ever leaves on a pop.
    always_comb begin
        state_nxt = state;
        case (state)
            OCC_EMPTY: begin
                if (push) state_nxt = OCC_PART;
            end
            OCC_PART: begin
                if (push && !pop && count == CNT_LAST) begin
                    state_nxt = OCC_FULL;
                end else if (pop && !push && count == PTR_ONE) begin
                    state_nxt = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) state_nxt = OCC_PART;
            end
            default: state_nxt = OCC_EMPTY;
        endcase
    end

endmodule
